// File: rtl/i2c_scl_gen_pkg.sv
// Shared types and defaults for the I2C SCL bit-timing stage.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    WAIT_HIGH = 2'd2,
    HIGH      = 2'd3
  } scl_state_t;

  // 100 kHz SCL from a 50 MHz system clock
  localparam int I2C_HALF_PERIOD_DEF = 250;

endpackage

// File: rtl/i2c_scl_gen_if.sv
// Bus between the SCL generator (master) and the I2C FSM / SCL pad (slave).
interface i2c_scl_gen_if;
  logic i2c_scl_en;
  logic scl_line_in;
  logic i2c_scl_out;
  logic scl_oe;
  logic fall_pulse;
  logic mid_low_pulse;
  logic rise_pulse;
  logic mid_high_pulse;
  logic busy;
  logic stretch_err;

  modport master (
    input  i2c_scl_en, scl_line_in,
    output i2c_scl_out, scl_oe, fall_pulse, mid_low_pulse,
           rise_pulse, mid_high_pulse, busy, stretch_err
  );

  modport slave (
    output i2c_scl_en, scl_line_in,
    input  i2c_scl_out, scl_oe, fall_pulse, mid_low_pulse,
           rise_pulse, mid_high_pulse, busy, stretch_err
  );
endinterface

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: divides clk into the SCL waveform, gates it with
// i2c_scl_en and emits one-cycle phase strobes (fall, mid-low, rise,
// mid-high). Optional clock stretching with timeout: I2C_CLK_STRETCH_EN.
// HALF_PERIOD must be >= 4 and even; CNT_W must hold HALF_PERIOD-1.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int HALF_PERIOD     = I2C_HALF_PERIOD_DEF,
  parameter int CNT_W           = 16,
  parameter int STRETCH_TIMEOUT = 16'hFFFF
) (
  input  logic           clk,
  input  logic           reset,
  i2c_scl_gen_if.master  bus
);

  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] LP_MID    = CNT_W'(HALF_PERIOD / 2);

  scl_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_fall, r_mid_low, r_rise, r_mid_high, r_err;
  logic             w_fall, w_mid_low, w_rise, w_mid_high, w_err;

`ifdef I2C_CLK_STRETCH_EN
  localparam int SW = (STRETCH_TIMEOUT > 1) ? $clog2(STRETCH_TIMEOUT) : 1;
  logic [SW-1:0] r_scnt, w_scnt_nxt;

  // stretch counter: clks spent waiting for the slave to release SCL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_scnt <= '0;
    else       r_scnt <= w_scnt_nxt;
  end
`else
  // line sense is meaningless without stretching; keep it visibly unused
  logic w_unused_line;
  assign w_unused_line = bus.scl_line_in;
`endif

  // state, phase counter and registered strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_fall     <= 1'b0;
      r_mid_low  <= 1'b0;
      r_rise     <= 1'b0;
      r_mid_high <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fall     <= w_fall;
      r_mid_low  <= w_mid_low;
      r_rise     <= w_rise;
      r_mid_high <= w_mid_high;
      r_err      <= w_err;
    end
  end

  // next state / counter / strobes; strobes are registered so each one
  // lands one clk after the counter value that triggers it
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fall      = 1'b0;
    w_mid_low   = 1'b0;
    w_rise      = 1'b0;
    w_mid_high  = 1'b0;
    w_err       = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    w_scnt_nxt  = '0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.i2c_scl_en) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = LP_RELOAD;
          w_fall      = 1'b1;
        end
      end
      LOW: begin
        w_mid_low = (r_cnt == LP_MID);
        if (r_cnt == '0) w_state_nxt = WAIT_HIGH;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      WAIT_HIGH: begin
`ifdef I2C_CLK_STRETCH_EN
        if (bus.scl_line_in) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = LP_RELOAD;
          w_rise      = 1'b1;
        end else if (r_scnt == SW'(STRETCH_TIMEOUT - 1)) begin
          // slave never let go: abandon the period and release SCL
          w_state_nxt = IDLE;
          w_err       = 1'b1;
        end else begin
          w_scnt_nxt  = r_scnt + SW'(1);
        end
`else
        w_state_nxt = HIGH;
        w_cnt_nxt   = LP_RELOAD;
        w_rise      = 1'b1;
`endif
      end
      HIGH: begin
        w_mid_high = (r_cnt == LP_MID);
        if (r_cnt == '0) begin
          // enable only matters here, so a drop mid-period never makes a runt
          if (bus.i2c_scl_en) begin
            w_state_nxt = LOW;
            w_cnt_nxt   = LP_RELOAD;
            w_fall      = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // SCL is decoded from state so async reset releases it immediately
  assign bus.i2c_scl_out    = (r_state != LOW);
  assign bus.scl_oe         = (r_state == LOW);
  assign bus.busy           = (r_state != IDLE);
  assign bus.fall_pulse     = r_fall;
  assign bus.mid_low_pulse  = r_mid_low;
  assign bus.rise_pulse     = r_rise;
  assign bus.mid_high_pulse = r_mid_high;
`ifdef I2C_CLK_STRETCH_EN
  assign bus.stretch_err    = r_err;
`else
  assign bus.stretch_err    = 1'b0;
  logic w_unused_err;
  assign w_unused_err = r_err;
`endif

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Self-checking bench for i2c_scl_gen: a period-timeline model checked on
// every cycle, plus literal checks of latency, spacing and period lengths.
module tb_i2c_scl_gen;

  localparam int H  = 8;
  localparam int TO = 30;
`ifdef I2C_CLK_STRETCH_EN
  localparam int EXP_S = 20;
`else
  localparam int EXP_S = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line_stuck0 = 1'b0;
  int   n_tests = 0, n_fail = 0, cyc = 0;

  i2c_scl_gen_if bus();
  assign bus.scl_line_in = line_stuck0 ? 1'b0 : bus.i2c_scl_out;

  i2c_scl_gen #(.HALF_PERIOD(H), .CNT_W(16), .STRETCH_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // model: position m_t within the current SCL period (0 = fall clk),
  // m_s = stretch clks inserted before the high phase
  bit m_run = 0, m_err = 0;
  int m_t = 0, m_s = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_run = 0; m_t = 0; m_s = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (!m_run) begin
        if (bus.i2c_scl_en) begin m_run = 1; m_t = 0; m_s = 0; end
      end else if (m_t < H) begin
        m_t++;
      end else if (m_t == H + m_s) begin
`ifdef I2C_CLK_STRETCH_EN
        if (!bus.scl_line_in) begin
          if (m_s + 1 == TO) begin m_run = 0; m_err = 1; end
          else begin m_s++; m_t++; end
        end else m_t++;
`else
        m_t++;
`endif
      end else if (m_t == 2*H + m_s) begin
        if (bus.i2c_scl_en) begin m_t = 0; m_s = 0; end
        else m_run = 0;
      end else begin
        m_t++;
      end
    end
  end

  function automatic logic [7:0] model_vec();
    logic scl;
    scl = !(m_run && m_t < H);
    return {scl, ~scl,
            logic'(m_run && m_t == 0),
            logic'(m_run && m_t == H/2),
            logic'(m_run && m_t == H + 1 + m_s),
            logic'(m_run && m_t == H + 1 + m_s + H/2),
            logic'(m_run), logic'(m_err)};
  endfunction

  int  fall_q[$], ml_q[$], rise_q[$], mh_q[$], err_q[$], idle_q[$];
  logic prev_busy = 1'b0;
  logic [7:0] got_vec;

  // per-cycle compare against the model, and pulse-time logging
  initial forever begin
    @(negedge clk);
    got_vec = {bus.i2c_scl_out, bus.scl_oe, bus.fall_pulse, bus.mid_low_pulse,
               bus.rise_pulse, bus.mid_high_pulse, bus.busy, bus.stretch_err};
    n_tests++;
    if (got_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL cyc%0d outputs {scl,oe,fall,mlow,rise,mhigh,busy,err}: got %b expected %b",
               cyc, got_vec, model_vec());
    end
    if (bus.fall_pulse)     fall_q.push_back(cyc);
    if (bus.mid_low_pulse)  ml_q.push_back(cyc);
    if (bus.rise_pulse)     rise_q.push_back(cyc);
    if (bus.mid_high_pulse) mh_q.push_back(cyc);
    if (bus.stretch_err)    err_q.push_back(cyc);
    if (prev_busy && !bus.busy) idle_q.push_back(cyc);
    prev_busy = bus.busy;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic clearq();
    fall_q.delete(); ml_q.delete(); rise_q.delete();
    mh_q.delete(); err_q.delete(); idle_q.delete();
  endtask

  // sel: 0 fall, 1 rise, 2 busy low, 3 scl high; returns 1ns after the hit
  task automatic wait_sig(input int sel, input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = bus.fall_pulse;
        1:       hit = bus.rise_pulse;
        2:       hit = !bus.busy;
        default: hit = bus.i2c_scl_out;
      endcase
    end
    chk(name, int'(hit), 1);
    #1;
  endtask

  initial begin
    bus.i2c_scl_en = 1'b0;
    // reset state
    repeat (5) @(negedge clk);
    chk("rst_scl", int'(bus.i2c_scl_out), 1);
    chk("rst_oe", int'(bus.scl_oe), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pulses", int'({bus.fall_pulse, bus.mid_low_pulse, bus.rise_pulse,
                            bus.mid_high_pulse, bus.stretch_err}), 0);
    #2 reset = 1'b0;
    clearq();
    repeat (100) @(negedge clk);
    chk("idle_falls", fall_q.size(), 0);
    chk("idle_rises", rise_q.size(), 0);
    chk("idle_scl", int'(bus.i2c_scl_out), 1);

    // three periods, then drop enable at LOW cnt==5 of the third
    clearq();
    bus.i2c_scl_en = 1'b1;
    @(negedge clk);
    chk("latency_scl", int'(bus.i2c_scl_out), 0);
    chk("latency_fall", int'(bus.fall_pulse), 1);
    wait_sig(0, 40, "wait_fall2");
    wait_sig(0, 40, "wait_fall3");
    @(negedge clk);
    @(negedge clk);
    bus.i2c_scl_en = 1'b0;
    wait_sig(2, 40, "wait_idle");
    chk("drop_to_idle", qat(idle_q, 0) - qat(fall_q, 2), 17);
    chk("drop_scl", int'(bus.i2c_scl_out), 1);
    repeat (20) @(negedge clk);
    #1;
    chk("n_fall", fall_q.size(), 3);
    chk("n_rise", rise_q.size(), 3);
    chk("n_mid_high", mh_q.size(), 3);
    chk("period1", qat(fall_q, 1) - qat(fall_q, 0), 17);
    chk("period2", qat(fall_q, 2) - qat(fall_q, 1), 17);
    chk("fall_mlow", qat(ml_q, 0) - qat(fall_q, 0), 4);
    chk("mlow_rise", qat(rise_q, 0) - qat(ml_q, 0), 5);
    chk("rise_mhigh", qat(mh_q, 0) - qat(rise_q, 0), 4);
    chk("mhigh_fall", qat(fall_q, 1) - qat(mh_q, 0), 4);

    // slave holds SCL low for 20 clks after release
    clearq();
    bus.i2c_scl_en = 1'b1;
    wait_sig(0, 10, "st_fall");
    bus.i2c_scl_en = 1'b0;
    wait_sig(3, 20, "st_release");
    line_stuck0 = 1'b1;
    repeat (20) @(negedge clk);
    line_stuck0 = 1'b0;
    wait_sig(2, 80, "st_idle");
    chk("stretch_rise", qat(rise_q, 0) - qat(fall_q, 0), 9 + EXP_S);
    chk("stretch_high", qat(idle_q, 0) - qat(rise_q, 0), 8);
    chk("stretch_mhigh", qat(mh_q, 0) - qat(rise_q, 0), 4);
    chk("stretch_noerr", err_q.size(), 0);

    // SCL stuck low for good
    clearq();
    bus.i2c_scl_en = 1'b1;
    wait_sig(0, 10, "to_fall");
    bus.i2c_scl_en = 1'b0;
    line_stuck0 = 1'b1;
    wait_sig(2, 100, "to_idle");
    line_stuck0 = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    chk("to_n_err", err_q.size(), 1);
    chk("to_err_time", qat(err_q, 0) - qat(fall_q, 0), H + TO);
    chk("to_idle_time", qat(idle_q, 0) - qat(fall_q, 0), H + TO);
    chk("to_n_rise", rise_q.size(), 0);
`else
    chk("to_n_err", err_q.size(), 0);
    chk("to_rise", qat(rise_q, 0) - qat(fall_q, 0), 9);
`endif
    chk("to_scl", int'(bus.i2c_scl_out), 1);

    // async reset at HIGH cnt==3, then restart
    bus.i2c_scl_en = 1'b1;
    wait_sig(0, 10, "rs_fall");
    wait_sig(1, 20, "rs_rise");
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rs_scl", int'(bus.i2c_scl_out), 1);
    chk("rs_busy", int'(bus.busy), 0);
    chk("rs_oe", int'(bus.scl_oe), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    clearq();
    wait_sig(0, 10, "rs2_fall");
    wait_sig(1, 20, "rs2_rise");
    bus.i2c_scl_en = 1'b0;
    wait_sig(2, 40, "rs2_idle");
    chk("rs2_rise_time", qat(rise_q, 0) - qat(fall_q, 0), 9);
    chk("rs2_idle_time", qat(idle_q, 0) - qat(fall_q, 0), 17);
    chk("rs2_n_fall", fall_q.size(), 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
